// File: rtl/servo_pwm_pkg.sv
// Shared defaults and width helpers for the servo/ESC PWM generator.
package servo_pwm_pkg;

  localparam int unsigned DEF_MIN_TICKS   = 255;
  localparam int unsigned DEF_FRAME_TICKS = 5100;
  localparam int unsigned DEF_NEUTRAL     = 127;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: target/current registers, per-frame slew toward the
// effective target and the registered pulse compare.
module servo_channel
  import servo_pwm_pkg::*;
#(
  parameter int unsigned VAL_W     = 8,
  parameter int unsigned CNT_W     = 13,
  parameter int unsigned MIN_TICKS = DEF_MIN_TICKS,
  parameter int unsigned STEP      = 4,
  parameter int unsigned NEUTRAL   = DEF_NEUTRAL
) (
  input  logic             clk_255kHz,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_i,
  input  logic             slew_i,
  input  logic             wr_i,
  input  logic [VAL_W-1:0] wr_data_i,
  input  logic             neutral_i,
  output logic             pwm_o,
  output logic [VAL_W-1:0] cur_o
);

  localparam logic [VAL_W-1:0] NEU = VAL_W'(NEUTRAL);
  // A step at least as large as the value range behaves like "no limit",
  // which is also how STEP = 0 is defined.
  localparam int unsigned STEP_C = (STEP == 0 || STEP >= 2 ** VAL_W) ? 2 ** VAL_W : STEP;
  localparam logic [VAL_W:0] STEP_X = (VAL_W + 1)'(STEP_C);

  logic [VAL_W-1:0] target_q, target_d;
  logic [VAL_W-1:0] cur_q, cur_d;
  logic             pwm_q;
  logic [VAL_W:0]   eff_x, cur_x, diff, next_x;
  logic [CNT_W-1:0] thresh;

  always_comb begin
    target_d = target_q;
    cur_d    = cur_q;
    eff_x    = {1'b0, (neutral_i ? NEU : target_q)};
    cur_x    = {1'b0, cur_q};
    diff     = '0;
    next_x   = cur_x;
    if (wr_i) target_d = wr_data_i;
    if (slew_i) begin
      if (eff_x >= cur_x) begin
        diff   = eff_x - cur_x;
        next_x = (diff <= STEP_X) ? eff_x : cur_x + STEP_X;
      end else begin
        diff   = cur_x - eff_x;
        next_x = (diff <= STEP_X) ? eff_x : cur_x - STEP_X;
      end
      cur_d = next_x[VAL_W-1:0];
    end
  end

  assign thresh = CNT_W'(MIN_TICKS) + CNT_W'(cur_q);

  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      target_q <= NEU;
      cur_q    <= NEU;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      pwm_q    <= (count_i < thresh);
    end
  end

  assign pwm_o = pwm_q;
  assign cur_o = cur_q;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo/ESC PWM generator: frame counter, write decode,
// write-timeout failsafe and one servo_channel per output.
module servo_pwm_array
  import servo_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned VAL_W          = 8,
  parameter int unsigned MIN_TICKS      = DEF_MIN_TICKS,
  parameter int unsigned FRAME_TICKS    = DEF_FRAME_TICKS,
  parameter int unsigned STEP           = 4,
  parameter int unsigned NEUTRAL        = DEF_NEUTRAL,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input  logic                        clk_255kHz,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [width_of(NUM_CH)-1:0] wr_chan,
  input  logic [VAL_W-1:0]            wr_data,
  input  logic                        pause,
  output logic [NUM_CH-1:0]           pwm,
  output logic [NUM_CH*VAL_W-1:0]     cur_value,
  output logic                        frame_start,
  output logic                        timed_out
);

  localparam int unsigned CH_W  = width_of(NUM_CH);
  localparam int unsigned CNT_W = width_of(FRAME_TICKS);
  localparam int unsigned TO_W  = width_of(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_FRAMES);

  if (MIN_TICKS + (2 ** VAL_W) - 1 >= FRAME_TICKS) begin : g_bad_timing
    $error("servo_pwm_array: longest pulse does not fit in the frame");
  end
  if (NEUTRAL >= 2 ** VAL_W) begin : g_bad_neutral
    $error("servo_pwm_array: NEUTRAL out of value range");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_pwm_array: NUM_CH must be 1..16");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timed_out_q, timed_out_d;
  logic             frame_start_q;
  logic             wrap, wr_valid, go_neutral;

  assign wrap       = (count_q == LAST);
  assign wr_valid   = wr_en && (32'(wr_chan) < NUM_CH);
  assign go_neutral = pause | timed_out_q;
  assign count_d    = wrap ? '0 : count_q + 1'b1;

  // A valid write wins over a wrap on the same edge.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    if (wr_valid) begin
      to_cnt_d    = '0;
      timed_out_d = 1'b0;
    end else if (wrap && TIMEOUT_FRAMES != 0) begin
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_d == TO_MAX) timed_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      count_q       <= '0;
      to_cnt_q      <= '0;
      timed_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      to_cnt_q      <= to_cnt_d;
      timed_out_q   <= timed_out_d;
      frame_start_q <= wrap;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    servo_channel #(
      .VAL_W    (VAL_W),
      .CNT_W    (CNT_W),
      .MIN_TICKS(MIN_TICKS),
      .STEP     (STEP),
      .NEUTRAL  (NEUTRAL)
    ) u_ch (
      .clk_255kHz(clk_255kHz),
      .reset     (reset),
      .count_i   (count_q),
      .slew_i    (wrap),
      .wr_i      (wr_valid && (wr_chan == CH_W'(gi))),
      .wr_data_i (wr_data),
      .neutral_i (go_neutral),
      .pwm_o     (pwm[gi]),
      .cur_o     (cur_value[gi*VAL_W +: VAL_W])
    );
  end

  assign frame_start = frame_start_q;
  assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: cycle-accurate reference model on a slewed,
// timed-out instance plus table-driven checks on an unlimited-step instance.
module tb_servo_pwm_array;

  localparam int VW     = 5;
  localparam int MIN    = 10;
  localparam int FT     = 60;
  localparam int NEU    = 15;
  localparam int NCH_A  = 3;
  localparam int STEP_A = 2;
  localparam int TO_A   = 12;
  localparam int NCH_B  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                a_wr_en, a_pause, a_fs, a_to;
  logic [1:0]          a_wr_chan;
  logic [VW-1:0]       a_wr_data;
  logic [NCH_A-1:0]    a_pwm;
  logic [NCH_A*VW-1:0] a_cur;

  logic                b_wr_en, b_pause, b_fs, b_to;
  logic [1:0]          b_wr_chan;
  logic [VW-1:0]       b_wr_data;
  logic [NCH_B-1:0]    b_pwm;
  logic [NCH_B*VW-1:0] b_cur;

  servo_pwm_array #(
    .NUM_CH(NCH_A), .VAL_W(VW), .MIN_TICKS(MIN), .FRAME_TICKS(FT),
    .STEP(STEP_A), .NEUTRAL(NEU), .TIMEOUT_FRAMES(TO_A)
  ) dut_a (
    .clk_255kHz(clk), .reset(reset), .wr_en(a_wr_en), .wr_chan(a_wr_chan),
    .wr_data(a_wr_data), .pause(a_pause), .pwm(a_pwm), .cur_value(a_cur),
    .frame_start(a_fs), .timed_out(a_to)
  );

  servo_pwm_array #(
    .NUM_CH(NCH_B), .VAL_W(VW), .MIN_TICKS(MIN), .FRAME_TICKS(FT),
    .STEP(0), .NEUTRAL(NEU), .TIMEOUT_FRAMES(0)
  ) dut_b (
    .clk_255kHz(clk), .reset(reset), .wr_en(b_wr_en), .wr_chan(b_wr_chan),
    .wr_data(b_wr_data), .pause(b_pause), .pwm(b_pwm), .cur_value(b_cur),
    .frame_start(b_fs), .timed_out(b_to)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model of dut_a, advanced once per clock edge.
  int               m_tgt[NCH_A];
  int               m_cur[NCH_A];
  int               m_pos, m_since;
  logic             m_to, m_fs;
  logic [NCH_A-1:0] m_pwm;

  int meas_a[NCH_A];
  int meas_b[NCH_B];

  function automatic int slew(input int c, input int e, input int step);
    int d;
    if (step == 0) return e;
    d = e - c;
    if (d > step) d = step;
    if (d < -step) d = -step;
    return c + d;
  endfunction

  task automatic model_edge();
    bit wrap;
    int eff;
    if (reset) begin
      m_pos = 0; m_pwm = '0; m_fs = 1'b0; m_to = 1'b0; m_since = 0;
      for (int k = 0; k < NCH_A; k++) begin
        m_tgt[k] = NEU;
        m_cur[k] = NEU;
      end
      return;
    end
    wrap = (m_pos == FT - 1);
    for (int k = 0; k < NCH_A; k++) m_pwm[k] = (m_pos < MIN + m_cur[k]);
    if (wrap) begin
      for (int k = 0; k < NCH_A; k++) begin
        eff = (a_pause || m_to) ? NEU : m_tgt[k];
        m_cur[k] = slew(m_cur[k], eff, STEP_A);
      end
    end
    if (a_wr_en && a_wr_chan < NCH_A) begin
      m_tgt[a_wr_chan] = int'(a_wr_data);
      m_since = 0;
      m_to = 1'b0;
    end else if (wrap && TO_A != 0) begin
      if (m_since < TO_A) m_since++;
      if (m_since == TO_A) m_to = 1'b1;
    end
    m_fs  = wrap;
    m_pos = wrap ? 0 : m_pos + 1;
  endtask

  task automatic tick();
    logic [NCH_A*VW-1:0] ec;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NCH_A; k++) ec[k*VW +: VW] = VW'(m_cur[k]);
    n_cmp++;
    if ({a_pwm, a_cur, a_fs, a_to} !== {m_pwm, ec, m_fs, m_to}) begin
      n_bad++;
      $display("FAIL model_a cycle %0d: got pwm=%b cur=%h fs=%b to=%b, expected pwm=%b cur=%h fs=%b to=%b",
               cyc, a_pwm, a_cur, a_fs, a_to, m_pwm, ec, m_fs, m_to);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic to_frame_start();
    int guard = 0;
    do begin
      tick();
      guard++;
    end while (m_pos != 0 && guard < 2 * FT);
  endtask

  // Called at a frame start; ends at the next frame start.
  task automatic measure();
    for (int k = 0; k < NCH_A; k++) meas_a[k] = 0;
    for (int k = 0; k < NCH_B; k++) meas_b[k] = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      for (int k = 0; k < NCH_A; k++) if (a_pwm[k] === 1'b1) meas_a[k]++;
      for (int k = 0; k < NCH_B; k++) if (b_pwm[k] === 1'b1) meas_b[k]++;
    end
  endtask

  task automatic write_a(input int chan, input int data);
    a_wr_en = 1'b1; a_wr_chan = 2'(chan); a_wr_data = VW'(data);
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic write_b(input int chan, input int data);
    b_wr_en = 1'b1; b_wr_chan = 2'(chan); b_wr_data = VW'(data);
    tick();
    b_wr_en = 1'b0;
  endtask

  typedef struct {
    int chan;
    int data;
    int exp_w;
  } bvec_t;

  bvec_t tbl[5];
  int    rates[3];

  initial begin
    tbl[0] = '{0, 0, 10};
    tbl[1] = '{1, 31, 41};
    tbl[2] = '{2, 5, 15};
    tbl[3] = '{3, 20, 30};
    tbl[4] = '{0, 17, 27};
    rates[0] = 20; rates[1] = 400; rates[2] = 3000;

    reset = 1'b1;
    a_wr_en = 1'b0; a_wr_chan = '0; a_wr_data = '0; a_pause = 1'b0;
    b_wr_en = 1'b0; b_wr_chan = '0; b_wr_data = '0; b_pause = 1'b0;
    tick();
    tick();
    chk("reset_cur_a", 32'(a_cur), 32'({3{5'd15}}));
    chk("reset_cur_b", 32'(b_cur), 32'({4{5'd15}}));
    chk("reset_pwm_a", 32'(a_pwm), 0);
    chk("reset_pwm_b", 32'(b_pwm), 0);
    chk("reset_fs_a", 32'(a_fs), 0);
    chk("reset_to_a", 32'(a_to), 0);
    reset = 1'b0;

    // First frame after reset: neutral pulse on every channel.
    measure();
    for (int k = 0; k < NCH_A; k++) chk($sformatf("first_pulse_a%0d", k), meas_a[k], MIN + NEU);
    for (int k = 0; k < NCH_B; k++) chk($sformatf("first_pulse_b%0d", k), meas_b[k], MIN + NEU);
    chk("frame_start_a", 32'(a_fs), 1);

    // Slew ch1 from 15 to 31 at 2 per frame.
    write_a(1, 31);
    for (int i = 0; i < 8; i++) begin
      to_frame_start();
      chk($sformatf("slew_up_f%0d", i + 1), 32'(a_cur[5 +: VW]), 17 + 2 * i);
    end
    measure();
    chk("slewed_pulse_a1", meas_a[1], 41);
    chk("other_pulse_a0", meas_a[0], 25);
    chk("other_pulse_a2", meas_a[2], 25);

    // Pause for 3 frames pulls ch1 toward neutral; release ramps back.
    write_a(1, 31);
    a_pause = 1'b1;
    for (int i = 0; i < 3; i++) to_frame_start();
    chk("pause_cur_a1", 32'(a_cur[5 +: VW]), 25);
    a_pause = 1'b0;
    for (int i = 0; i < 3; i++) to_frame_start();
    chk("unpause_cur_a1", 32'(a_cur[5 +: VW]), 31);

    // Unlimited step: each write shows up as a full pulse next frame.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 3; j++) tick();
      write_b(tbl[i].chan, tbl[i].data);
      to_frame_start();
      measure();
      chk($sformatf("tbl%0d_pulse_b%0d", i, tbl[i].chan), meas_b[tbl[i].chan], tbl[i].exp_w);
    end

    // Write landing on the last tick of a frame takes effect a frame later.
    for (int i = 0; i < FT - 1; i++) tick();
    chk("boundary_pos", m_pos, FT - 1);
    write_b(0, 3);
    chk("boundary_cur_old", 32'(b_cur[0 +: VW]), 17);
    measure();
    chk("boundary_pulse_old", meas_b[0], 27);
    chk("boundary_cur_new", 32'(b_cur[0 +: VW]), 3);
    measure();
    chk("boundary_pulse_new", meas_b[0], 13);

    // Write timeout on dut_a.
    to_frame_start();
    write_a(2, 28);
    for (int i = 0; i < TO_A - 1; i++) to_frame_start();
    chk("timeout_not_yet", 32'(a_to), 0);
    to_frame_start();
    chk("timeout_set", 32'(a_to), 1);
    for (int i = 0; i < 10; i++) to_frame_start();
    chk("timeout_cur_neutral", 32'(a_cur), 32'({3{5'd15}}));
    write_a(3, 1);
    chk("bad_chan_keeps_timeout", 32'(a_to), 1);
    write_a(2, 9);
    chk("write_clears_timeout", 32'(a_to), 0);

    // Randomized traffic against the model at three write densities.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 100 * FT; i++) begin
        a_wr_en   = ($urandom_range(rates[s] - 1) == 0);
        a_wr_chan = 2'($urandom_range(3));
        a_wr_data = VW'($urandom_range(31));
        if ($urandom_range(149) == 0) a_pause = ~a_pause;
        tick();
      end
    end
    a_wr_en = 1'b0;
    a_pause = 1'b0;
    chk("timeout_disabled_b", 32'(b_to), 0);

    // Reset in the middle of a pulse.
    to_frame_start();
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    chk("midreset_pwm_a", 32'(a_pwm), 0);
    chk("midreset_pwm_b", 32'(b_pwm), 0);
    chk("midreset_cur_a", 32'(a_cur), 32'({3{5'd15}}));
    chk("midreset_cur_b", 32'(b_cur), 32'({4{5'd15}}));
    chk("midreset_to_a", 32'(a_to), 0);
    reset = 1'b0;
    measure();
    chk("post_reset_pulse_a1", meas_a[1], MIN + NEU);
    chk("post_reset_pulse_b0", meas_b[0], MIN + NEU);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
